// File: rtl/prenc_arb.sv
// ============================================================================
//  Module   : prenc_arb
//  Brief    : Registered N-input priority encoder / arbiter, fixed-priority or
//             round-robin, with a valid/ack output handshake.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prenc_arb #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         mode,
    input  logic [N-1:0] d,
    input  logic         ack,
    output logic         valid,
    output logic [W-1:0] q,
    output logic [N-1:0] grant
);

    localparam logic [W-1:0] c_ptr_rst = W'(N - 1);
    localparam logic [N-1:0] c_one     = N'(1);

    logic         r_valid;
    logic [W-1:0] r_q;
    logic [N-1:0] r_grant;
    logic [W-1:0] r_ptr;

    logic         w_accept;
    logic         w_free;
    logic         w_load;
    logic [W-1:0] w_ptr_post;
    logic [W-1:0] w_sptr;
    logic [W-1:0] w_fix_idx;
    logic [W-1:0] w_rr_idx;
    logic         w_rr_found;
    logic [W-1:0] w_k;

    assign w_accept   = r_valid && ack;
    assign w_free     = !r_valid || ack;
    assign w_load     = w_free && en && (d != '0);
    assign w_ptr_post = (r_q == '0) ? c_ptr_rst : (r_q - W'(1));
    // An accepted index must not immediately win again, so search from the
    // post-accept pointer whenever an accept happens in this cycle.
    assign w_sptr     = w_accept ? w_ptr_post : r_ptr;

    // Fixed priority: the highest set bit is the last one seen.
    always_comb begin
        w_fix_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (d[i]) begin
                w_fix_idx = W'(i);
            end
        end
    end

    // Round-robin: descend from the search pointer, wrapping below 0 to N-1.
    always_comb begin
        int           pos;
        logic [W-1:0] pos_w;
        pos        = 0;
        pos_w      = '0;
        w_rr_idx   = '0;
        w_rr_found = 1'b0;
        for (int j = 0; j < N; j++) begin
            pos   = (int'(w_sptr) - j + N) % N;
            pos_w = W'(pos);
            if (!w_rr_found && d[pos_w]) begin
                w_rr_idx   = pos_w;
                w_rr_found = 1'b1;
            end
        end
    end

    assign w_k = mode ? w_rr_idx : w_fix_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_q     <= '0;
            r_grant <= '0;
            r_ptr   <= c_ptr_rst;
        end else begin
            if (w_accept) begin
                r_ptr <= w_ptr_post;
            end
            if (w_load) begin
                r_valid <= 1'b1;
                r_q     <= w_k;
                r_grant <= c_one << w_k;
            end else if (w_free) begin
                r_valid <= 1'b0;
                r_q     <= '0;
                r_grant <= '0;
            end
        end
    end

    assign valid = r_valid;
    assign q     = r_q;
    assign grant = r_grant;

endmodule

`default_nettype wire

// File: tb/tb_prenc_arb.sv
// ============================================================================
//  Module   : tb_prenc_arb
//  Brief    : Directed scoreboard bench for prenc_arb at N=8, N=5 and N=2.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prenc_arb;

    typedef struct packed {
        logic       v;
        logic [2:0] q;
        logic [7:0] g;
    } exp_t;

    logic clk;
    logic rst;

    logic       en8, mode8, ack8, valid8;
    logic [7:0] d8, grant8;
    logic [2:0] q8;

    logic       en5, mode5, ack5, valid5;
    logic [4:0] d5, grant5;
    logic [2:0] q5;

    logic       en2, mode2, ack2, valid2;
    logic [1:0] d2, grant2;
    logic [0:0] q2;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_step   = 0;

    prenc_arb #(.N(8)) u_dut8 (
        .clk(clk), .rst(rst), .en(en8), .mode(mode8), .d(d8), .ack(ack8),
        .valid(valid8), .q(q8), .grant(grant8)
    );

    prenc_arb #(.N(5)) u_dut5 (
        .clk(clk), .rst(rst), .en(en5), .mode(mode5), .d(d5), .ack(ack5),
        .valid(valid5), .q(q5), .grant(grant5)
    );

    prenc_arb #(.N(2)) u_dut2 (
        .clk(clk), .rst(rst), .en(en2), .mode(mode2), .d(d2), .ack(ack2),
        .valid(valid2), .q(q2), .grant(grant2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic v, input logic [2:0] qq);
        exp_t e;
        e.v = v;
        e.q = v ? qq : 3'd0;
        e.g = v ? (8'h01 << qq) : 8'h00;
        return e;
    endfunction

    function automatic exp_t obs8();
        return {valid8, q8, grant8};
    endfunction

    function automatic exp_t obs5();
        return {valid5, q5, 3'b000, grant5};
    endfunction

    function automatic exp_t obs2();
        return {valid2, 2'b00, q2, 6'b000000, grant2};
    endfunction

    task automatic check(input string tag, input exp_t obs);
        exp_t e;
        n_assert++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL %s: scoreboard empty, observed v=%0b q=%0d g=%h", tag, obs.v, obs.q, obs.g);
        end else begin
            e = sb.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s: observed v=%0b q=%0d g=%h, expected v=%0b q=%0d g=%h",
                       tag, obs.v, obs.q, obs.g, e.v, e.q, e.g);
            end
        end
    endtask

    // Drive one cycle of inputs, push the expected result, compare after the edge.
    task automatic step8(input logic e, input logic m, input logic [7:0] dd,
                         input logic a, input logic ev, input logic [2:0] eq);
        en8 = e; mode8 = m; d8 = dd; ack8 = a;
        sb.push_back(mk(ev, eq));
        n_step++;
        @(posedge clk); #1;
        check($sformatf("n8_step%0d", n_step), obs8());
    endtask

    task automatic step5(input logic m, input logic [4:0] dd, input logic [2:0] eq);
        en5 = 1'b1; mode5 = m; d5 = dd; ack5 = 1'b1;
        sb.push_back(mk(1'b1, eq));
        n_step++;
        @(posedge clk); #1;
        check($sformatf("n5_step%0d", n_step), obs5());
    endtask

    task automatic step2(input logic m, input logic [1:0] dd, input logic [2:0] eq);
        en2 = 1'b1; mode2 = m; d2 = dd; ack2 = 1'b1;
        sb.push_back(mk(1'b1, eq));
        n_step++;
        @(posedge clk); #1;
        check($sformatf("n2_step%0d", n_step), obs2());
    endtask

    initial begin
        en8 = 0; mode8 = 0; d8 = '0; ack8 = 0;
        en5 = 0; mode5 = 0; d5 = '0; ack5 = 0;
        en2 = 0; mode2 = 0; d2 = '0; ack2 = 0;
        rst = 1'b1;
        @(posedge clk); #1;
        sb.push_back(mk(1'b0, 3'd0));
        check("reset_n8", obs8());
        sb.push_back(mk(1'b0, 3'd0));
        check("reset_n5", obs5());
        rst = 1'b0;

        // Fixed priority
        step8(1, 0, 8'b0010_0110, 1, 1, 3'd5);
        step8(1, 0, 8'h01,        1, 1, 3'd0);
        step8(1, 0, 8'h00,        1, 0, 3'd0);

        // Round-robin, sparse then full request set (pointer starts at 7)
        step8(1, 1, 8'b1001_0010, 1, 1, 3'd7);
        step8(1, 1, 8'b1001_0010, 1, 1, 3'd4);
        step8(1, 1, 8'b1001_0010, 1, 1, 3'd1);
        step8(1, 1, 8'b1001_0010, 1, 1, 3'd7);
        for (int i = 6; i >= 0; i--) begin
            step8(1, 1, 8'hFF, 1, 1, 3'(i));
        end
        step8(1, 1, 8'hFF, 1, 1, 3'd7);

        // Backpressure: held output ignores d/en/mode until ack
        step8(1, 0, 8'h20, 1, 1, 3'd5);
        step8(1, 0, 8'h80, 0, 1, 3'd5);
        step8(1, 0, 8'h80, 0, 1, 3'd5);
        step8(0, 1, 8'h80, 0, 1, 3'd5);
        step8(1, 0, 8'h80, 1, 1, 3'd7);

        // Accept and load together: search starts from the post-accept pointer
        step8(1, 1, 8'h81, 1, 1, 3'd0);
        step8(1, 1, 8'h81, 1, 1, 3'd7);
        step8(1, 1, 8'h00, 1, 0, 3'd0);

        // Enable gating
        for (int i = 0; i < 4; i++) begin
            step8(0, 0, 8'hFF, 0, 0, 3'd0);
        end
        step8(1, 0, 8'hFF, 0, 1, 3'd7);

        // Asynchronous reset mid-transaction
        step8(1, 0, 8'h20, 1, 1, 3'd5);
        ack8 = 1'b0;
        #2 rst = 1'b1;
        #1;
        sb.push_back(mk(1'b0, 3'd0));
        check("async_reset", obs8());
        @(posedge clk); #1;
        rst = 1'b0;
        step8(1, 1, 8'hFF, 1, 1, 3'd7);
        step8(1, 1, 8'hFF, 1, 1, 3'd6);
        step8(0, 0, 8'h00, 1, 0, 3'd0);

        // N=5 round-robin wrap
        step5(1, 5'b11111, 3'd4);
        step5(1, 5'b11111, 3'd3);
        step5(1, 5'b11111, 3'd2);
        step5(1, 5'b11111, 3'd1);
        step5(1, 5'b11111, 3'd0);
        step5(1, 5'b11111, 3'd4);

        // N=2 fixed priority
        step2(0, 2'b11, 3'd1);
        step2(0, 2'b01, 3'd0);
        step2(0, 2'b10, 3'd1);

        n_assert++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain: observed %0d left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
